// File: rtl/cpu_ctrl_sequencer.sv
// cpu_ctrl_sequencer
// ------------------
// Multi-cycle fetch/decode/execute controller for the tiny CPU. It owns the
// program counter and drives the instruction/accumulator register controls.
// Each instruction takes three clocks (FETCH, DECODE, EXEC). An HLT opcode
// (F) parks the controller in HALT until reset.
//
// Ports:
//   CLK       in   rising-edge clock
//   RST_N     in   asynchronous active-low reset
//   START     in   leaves IDLE when high (sampled only in IDLE)
//   MEM_DATA  in   instruction byte at address PC: [7:4] opcode, [3:0] operand
//   ZERO      in   accumulator-equals-zero flag, sampled in EXEC by JZ
//   PC        out  program counter (ADDR_W bits)
//   IR_EN     out  instruction register load enable (FETCH)
//   ACC_EN    out  accumulator load enable
//   ACC_CLR   out  accumulator synchronous clear (only with ACC_EN)
//   ALU_OP    out  00 ADD, 01 SUB
//   HALTED    out  high while in HALT
//   STATE     out  current state code, for debug
//   RETIRED   out  retired-instruction counter (only with SEQ_RETIRE_CNT_EN)
//
// Optional build macro: SEQ_RETIRE_CNT_EN adds the saturating 16-bit
// RETIRED counter, incremented on every edge leaving EXEC.
//
// Handshake note: START is a level, not a valid/ready pair; it is only looked
// at in IDLE and needs no acknowledge.

module cpu_ctrl_sequencer #(
    parameter int ADDR_W = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              START,
    input  logic [7:0]        MEM_DATA,
    input  logic              ZERO,
    output logic [ADDR_W-1:0] PC,
    output logic              IR_EN,
    output logic              ACC_EN,
    output logic              ACC_CLR,
    output logic [1:0]        ALU_OP,
    output logic              HALTED,
`ifdef SEQ_RETIRE_CNT_EN
    output logic [15:0]       RETIRED,
`endif
    output logic [2:0]        STATE
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    localparam logic [3:0] OP_CLRA = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_JMP  = 4'h4;
    localparam logic [3:0] OP_JZ   = 4'h5;
    localparam logic [3:0] OP_HLT  = 4'hF;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [3:0]        op_q, op_d;
    logic [3:0]        opd_q, opd_d;
    logic              ir_en_q, acc_en_q, acc_clr_q, halted_q;
    logic [1:0]        alu_op_q;
    logic              exec_d;
    logic              acc_op_d;

    // Next-state, PC and opcode latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        op_d    = op_q;
        opd_d   = opd_q;
        case (state_q)
            S_IDLE: begin
                if (START) state_d = S_FETCH;
            end
            S_FETCH: begin
                op_d    = MEM_DATA[7:4];
                opd_d   = MEM_DATA[3:0];
                state_d = S_DECODE;
            end
            S_DECODE: begin
                state_d = (op_q == OP_HLT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (op_q == OP_JMP || (op_q == OP_JZ && ZERO))
                    pc_d = ADDR_W'(opd_q);
                else
                    pc_d = pc_q + ADDR_W'(1);
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                // Codes 5-7 are unreachable in normal operation; recover.
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the
    // state register and never glitch.
    assign exec_d   = (state_d == S_EXEC);
    assign acc_op_d = (op_d == OP_CLRA) || (op_d == OP_ADD) || (op_d == OP_SUB);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            op_q      <= '0;
            opd_q     <= '0;
            ir_en_q   <= 1'b0;
            acc_en_q  <= 1'b0;
            acc_clr_q <= 1'b0;
            alu_op_q  <= 2'b00;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_q      <= op_d;
            opd_q     <= opd_d;
            ir_en_q   <= (state_d == S_FETCH);
            acc_en_q  <= exec_d && acc_op_d;
            acc_clr_q <= exec_d && (op_d == OP_CLRA);
            alu_op_q  <= (exec_d && op_d == OP_SUB) ? 2'b01 : 2'b00;
            halted_q  <= (state_d == S_HALT);
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] retired_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            retired_q <= '0;
        else if (state_q == S_EXEC && retired_q != 16'hFFFF)
            retired_q <= retired_q + 16'd1;
    end

    assign RETIRED = retired_q;
`endif

    assign PC      = pc_q;
    assign IR_EN   = ir_en_q;
    assign ACC_EN  = acc_en_q;
    assign ACC_CLR = acc_clr_q;
    assign ALU_OP  = alu_op_q;
    assign HALTED  = halted_q;
    assign STATE   = state_q;

endmodule

// File: tb/tb_cpu_ctrl_sequencer.sv
// Directed, table-driven bench for cpu_ctrl_sequencer (ADDR_W=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cpu_ctrl_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       START;
    logic [7:0] MEM_DATA;
    logic       ZERO;
    logic [3:0] PC;
    logic       IR_EN, ACC_EN, ACC_CLR, HALTED;
    logic [1:0] ALU_OP;
    logic [2:0] STATE;
`ifdef SEQ_RETIRE_CNT_EN
    logic [15:0] RETIRED;
`endif

    int total = 0;
    int bad   = 0;
    logic [3:0] cur_pc;

    cpu_ctrl_sequencer #(.ADDR_W(4)) dut (
        .CLK      (CLK),
        .RST_N    (RST_N),
        .START    (START),
        .MEM_DATA (MEM_DATA),
        .ZERO     (ZERO),
        .PC       (PC),
        .IR_EN    (IR_EN),
        .ACC_EN   (ACC_EN),
        .ACC_CLR  (ACC_CLR),
        .ALU_OP   (ALU_OP),
        .HALTED   (HALTED),
`ifdef SEQ_RETIRE_CNT_EN
        .RETIRED  (RETIRED),
`endif
        .STATE    (STATE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0] instr;
        logic       zero;
        logic       acc_en;
        logic       acc_clr;
        logic [1:0] alu;
        logic [3:0] pc_after;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        RST_N    = 1'b0;
        START    = 1'b0;
        MEM_DATA = 8'h00;
        ZERO     = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        cur_pc = 4'd0;
    endtask

    // From IDLE: pulse START, returns at the falling edge inside FETCH.
    task automatic do_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    // Entered at the falling edge inside FETCH; returns inside the next FETCH.
    task automatic do_instr(input vec_t v);
        chk("fetch_state", 32'(STATE), 32'd1);
        chk("fetch_ir_en", 32'(IR_EN), 32'd1);
        chk("fetch_acc_en", 32'(ACC_EN), 32'd0);
        MEM_DATA = v.instr;
        @(negedge CLK);
        MEM_DATA = 8'hxx;
        chk("decode_state", 32'(STATE), 32'd2);
        chk("decode_en", 32'({IR_EN, ACC_EN, ACC_CLR, ALU_OP}), 32'd0);
        ZERO = v.zero;
        @(negedge CLK);
        chk("exec_state", 32'(STATE), 32'd3);
        chk("exec_ir_en", 32'(IR_EN), 32'd0);
        chk("exec_acc_en", 32'(ACC_EN), 32'(v.acc_en));
        chk("exec_acc_clr", 32'(ACC_CLR), 32'(v.acc_clr));
        chk("exec_alu_op", 32'(ALU_OP), 32'(v.alu));
        chk("exec_pc_hold", 32'(PC), 32'(cur_pc));
        @(negedge CLK);
        ZERO = 1'b0;
        chk("next_pc", 32'(PC), 32'(v.pc_after));
        cur_pc = v.pc_after;
    endtask

    // Entered inside FETCH; issues HLT and holds in HALT for 20 clocks.
    task automatic do_halt();
        MEM_DATA = 8'hF0;
        @(negedge CLK);
        chk("hlt_decode_state", 32'(STATE), 32'd2);
        @(negedge CLK);
        chk("halt_state", 32'(STATE), 32'd4);
        chk("halt_halted", 32'(HALTED), 32'd1);
        for (int i = 0; i < 20; i++) begin
            START = 1'($urandom_range(0, 1));
            @(negedge CLK);
            chk("halt_hold_state", 32'(STATE), 32'd4);
            chk("halt_hold_pc", 32'(PC), 32'(cur_pc));
            chk("halt_hold_en", 32'({IR_EN, ACC_EN, ACC_CLR, ALU_OP}), 32'd0);
            chk("halt_hold_halted", 32'(HALTED), 32'd1);
        end
        START = 1'b0;
    endtask

    initial begin
        // instr, zero, acc_en, acc_clr, alu, pc_after
        vecs[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1};
        vecs[1]  = '{8'h00, 1'b1, 1'b0, 1'b0, 2'b00, 4'd2};
        vecs[2]  = '{8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 4'd3};
        vecs[3]  = '{8'h10, 1'b0, 1'b1, 1'b1, 2'b00, 4'd4};
        vecs[4]  = '{8'h20, 1'b0, 1'b1, 1'b0, 2'b00, 4'd5};
        vecs[5]  = '{8'h30, 1'b0, 1'b1, 1'b0, 2'b01, 4'd6};
        vecs[6]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 2'b00, 4'd10};
        vecs[7]  = '{8'h5A, 1'b0, 1'b0, 1'b0, 2'b00, 4'd11};
        vecs[8]  = '{8'h47, 1'b1, 1'b0, 1'b0, 2'b00, 4'd7};
        vecs[9]  = '{8'h47, 1'b0, 1'b0, 1'b0, 2'b00, 4'd7};
        vecs[10] = '{8'h4F, 1'b0, 1'b0, 1'b0, 2'b00, 4'd15};
        vecs[11] = '{8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 4'd0};
        vecs[12] = '{8'h60, 1'b1, 1'b0, 1'b0, 2'b00, 4'd1};
        vecs[13] = '{8'hE5, 1'b0, 1'b0, 1'b0, 2'b00, 4'd2};
        vecs[14] = '{8'h2F, 1'b0, 1'b1, 1'b0, 2'b00, 4'd3};
        vecs[15] = '{8'h53, 1'b0, 1'b0, 1'b0, 2'b00, 4'd4};

        // Reset values, checked while reset is still asserted.
        RST_N    = 1'b0;
        START    = 1'b0;
        MEM_DATA = 8'h00;
        ZERO     = 1'b0;
        @(negedge CLK);
        chk("rst_state", 32'(STATE), 32'd0);
        chk("rst_pc", 32'(PC), 32'd0);
        chk("rst_outs", 32'({IR_EN, ACC_EN, ACC_CLR, ALU_OP, HALTED}), 32'd0);
`ifdef SEQ_RETIRE_CNT_EN
        chk("rst_retired", 32'(RETIRED), 32'd0);
`endif
        RST_N = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        chk("idle_wait", 32'(STATE), 32'd0);
        cur_pc = 4'd0;

        // Table run, including branches and the PC wrap at 15.
        do_start();
        for (int i = 0; i < 16; i++) do_instr(vecs[i]);
`ifdef SEQ_RETIRE_CNT_EN
        chk("retired_16", 32'(RETIRED), 32'd16);
`endif
        do_halt();

        // Five NOPs then HLT; HLT itself does not retire.
        do_reset();
        do_start();
        for (int i = 0; i < 5; i++)
            do_instr('{8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 4'(i + 1)});
        do_halt();
`ifdef SEQ_RETIRE_CNT_EN
        chk("retired_5", 32'(RETIRED), 32'd5);
`endif

        // Asynchronous reset in the middle of an ADD execute cycle.
        do_reset();
        do_start();
        do_instr('{8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 4'd1});
        do_instr('{8'h00, 1'b0, 1'b0, 1'b0, 2'b00, 4'd2});
        MEM_DATA = 8'h20;
        @(negedge CLK);
        @(negedge CLK);
        chk("pre_rst_acc_en", 32'(ACC_EN), 32'd1);
        chk("pre_rst_pc", 32'(PC), 32'd2);
        #2 RST_N = 1'b0;
        #1;
        chk("async_acc_en", 32'(ACC_EN), 32'd0);
        chk("async_pc", 32'(PC), 32'd0);
        chk("async_state", 32'(STATE), 32'd0);
        @(negedge CLK);
        chk("in_rst_outs", 32'({IR_EN, ACC_EN, ACC_CLR, ALU_OP, HALTED}), 32'd0);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("post_rst_idle", 32'(STATE), 32'd0);
            chk("post_rst_ir_en", 32'(IR_EN), 32'd0);
        end
        do_start();
        chk("resume_state", 32'(STATE), 32'd1);
        chk("resume_pc", 32'(PC), 32'd0);
        chk("resume_ir_en", 32'(IR_EN), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
